// File: rtl/bitblaster_sequencer_if.sv
// Control interface between the sequencer and its surroundings: the exec
// request and switch data coming in, handshake and datapath controls going out.
interface bitblaster_sequencer_if #(
  parameter int DATA_W = 10,
  parameter int RA_W   = 2,
  parameter int OPC_W  = 4
);
  logic              exec;
  logic [DATA_W-1:0] inst_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] imm;
  logic              imm_oe;
  logic [RA_W-1:0]   rin;
  logic [RA_W-1:0]   rout;
  logic              enw;
  logic              enr;
  logic              ain;
  logic              gin;
  logic              gout;
  logic [OPC_W-1:0]  alucont;
  logic              ext;
  logic              irin;

  // Upstream side: button/switch logic and whatever observes the handshake.
  modport master (
    output exec, inst_in,
    input  busy, done, err, imm, imm_oe, rin, rout, enw, enr,
    input  ain, gin, gout, alucont, ext, irin
  );

  // Sequencer side.
  modport slave (
    input  exec, inst_in,
    output busy, done, err, imm, imm_oe, rin, rout, enw, enr,
    output ain, gin, gout, alucont, ext, irin
  );
endinterface

// File: rtl/bitblaster_sequencer.sv
// Instruction register and timestep FSM for the bit-blaster processor.
// Fetches an instruction from the switch bus on exec, then steps through
// FETCH/T1/T2/T3 driving regfile, A, G, ALU and bus-enable controls.
// All controls are registered: the next control word is decoded from the
// next state and next IR value, so outputs change cleanly on the clock edge.
module bitblaster_sequencer #(
  parameter int DATA_W = 10,
  parameter int RA_W   = 2,
  parameter int OPC_W  = 4
) (
  input logic                  clk,
  input logic                  rst,
  bitblaster_sequencer_if.slave ctl
);

  localparam int IMM_W = DATA_W - 2 - RA_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    T1,
    T2,
    T3
  } state_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] imm;
    logic              imm_oe;
    logic [RA_W-1:0]   rin;
    logic [RA_W-1:0]   rout;
    logic              enw;
    logic              enr;
    logic              ain;
    logic              gin;
    logic              gout;
    logic [OPC_W-1:0]  alucont;
    logic              ext;
    logic              irin;
  } ctrl_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  ctrl_t             ctrl_q, ctrl_d;

  logic [1:0]        prefix;
  logic [RA_W-1:0]   rx;
  logic [RA_W-1:0]   ry;
  logic [OPC_W-1:0]  op;
  logic [IMM_W-1:0]  immv;
  logic              is_ld, is_cp, is_alu, is_imm, is_ill;

  // IR loads only at the end of FETCH; decode always looks at the value the
  // IR will hold next cycle so T1 controls can be registered from inst_in.
  always_comb begin
    ir_d   = (state_q == FETCH) ? ctl.inst_in : ir_q;
    prefix = ir_d[DATA_W-1 -: 2];
    rx     = ir_d[DATA_W-3 -: RA_W];
    ry     = ir_d[DATA_W-3-RA_W -: RA_W];
    op     = ir_d[OPC_W-1:0];
    immv   = ir_d[IMM_W-1:0];
    is_ld  = (prefix == 2'b00) && (op == OPC_W'(0));
    is_cp  = (prefix == 2'b00) && (op == OPC_W'(1));
    is_alu = (prefix == 2'b00) && (op >= OPC_W'(2)) && (op <= OPC_W'(11));
    is_imm = prefix[1];
    is_ill = !(is_ld || is_cp || is_alu || is_imm);
  end

  // Timestep sequencing; exec is only looked at in IDLE, so requests made
  // while busy are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctl.exec) state_d = FETCH;
      FETCH:   state_d = T1;
      T1:      state_d = (is_alu || is_imm) ? T2 : IDLE;
      T2:      state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control word for the state being entered, built from the next IR value.
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != IDLE);
    case (state_d)
      FETCH: begin
        ctrl_d.ext  = 1'b1;
        ctrl_d.irin = 1'b1;
      end
      T1: begin
        if (is_ld) begin
          ctrl_d.ext  = 1'b1;
          ctrl_d.rin  = rx;
          ctrl_d.enr  = 1'b1;
          ctrl_d.done = 1'b1;
        end else if (is_cp) begin
          ctrl_d.rout = ry;
          ctrl_d.enw  = 1'b1;
          ctrl_d.rin  = rx;
          ctrl_d.enr  = 1'b1;
          ctrl_d.done = 1'b1;
        end else if (is_ill) begin
          ctrl_d.err  = 1'b1;
          ctrl_d.done = 1'b1;
        end else begin
          ctrl_d.rout = rx;
          ctrl_d.enw  = 1'b1;
          ctrl_d.ain  = 1'b1;
        end
      end
      T2: begin
        ctrl_d.gin = 1'b1;
        if (is_imm) begin
          ctrl_d.imm_oe  = 1'b1;
          ctrl_d.imm     = {{(DATA_W-IMM_W){1'b0}}, immv};
          ctrl_d.alucont = prefix[0] ? OPC_W'(3) : OPC_W'(2);
        end else begin
          ctrl_d.rout    = ry;
          ctrl_d.enw     = 1'b1;
          ctrl_d.alucont = op;
        end
      end
      T3: begin
        ctrl_d.gout = 1'b1;
        ctrl_d.rin  = rx;
        ctrl_d.enr  = 1'b1;
        ctrl_d.done = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, IR and control registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctl.busy    = ctrl_q.busy;
  assign ctl.done    = ctrl_q.done;
  assign ctl.err     = ctrl_q.err;
  assign ctl.imm     = ctrl_q.imm;
  assign ctl.imm_oe  = ctrl_q.imm_oe;
  assign ctl.rin     = ctrl_q.rin;
  assign ctl.rout    = ctrl_q.rout;
  assign ctl.enw     = ctrl_q.enw;
  assign ctl.enr     = ctrl_q.enr;
  assign ctl.ain     = ctrl_q.ain;
  assign ctl.gin     = ctrl_q.gin;
  assign ctl.gout    = ctrl_q.gout;
  assign ctl.alucont = ctrl_q.alucont;
  assign ctl.ext     = ctrl_q.ext;
  assign ctl.irin    = ctrl_q.irin;

  // The shared bus never sees two drivers, and every working step has one.
  bus_at_most_one_driver: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ctrl_q.ext, ctrl_q.enw, ctrl_q.gout, ctrl_q.imm_oe}));

  bus_one_driver_when_active: assert property (@(posedge clk) disable iff (rst)
    (ctrl_q.busy && !ctrl_q.err) |-> $onehot({ctrl_q.ext, ctrl_q.enw, ctrl_q.gout, ctrl_q.imm_oe}));

endmodule

// File: tb/tb_bitblaster_sequencer.sv
// Self-checking bench for bitblaster_sequencer. Each instruction pushes its
// per-cycle stimulus and expected control word into queues; the scenario
// tasks replay the stimulus and compare every cycle against the queue head.
module tb_bitblaster_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] imm;
    logic       imm_oe;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw;
    logic       enr;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] alucont;
    logic       ext;
    logic       irin;
  } vec_t;

  logic clk;
  logic rst;

  int tests;
  int failures;

  vec_t        exp_q[$];
  string       name_q[$];
  logic [10:0] stim_q[$];

  bitblaster_sequencer_if #(.DATA_W(10), .RA_W(2), .OPC_W(4)) ifc ();

  bitblaster_sequencer #(.DATA_W(10), .RA_W(2), .OPC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t snap();
    vec_t v;
    v.busy    = ifc.busy;
    v.done    = ifc.done;
    v.err     = ifc.err;
    v.imm     = ifc.imm;
    v.imm_oe  = ifc.imm_oe;
    v.rin     = ifc.rin;
    v.rout    = ifc.rout;
    v.enw     = ifc.enw;
    v.enr     = ifc.enr;
    v.ain     = ifc.ain;
    v.gin     = ifc.gin;
    v.gout    = ifc.gout;
    v.alucont = ifc.alucont;
    v.ext     = ifc.ext;
    v.irin    = ifc.irin;
    return v;
  endfunction

  // Reference model: expected controls for step 0 (FETCH) .. 3 (T3).
  function automatic vec_t exp_step(input logic [9:0] w, input int step);
    vec_t       v;
    logic [1:0] pre;
    logic [1:0] rx, ry;
    logic [3:0] op;
    bit         ld, cp, alu, immop;
    pre   = w[9:8];
    rx    = w[7:6];
    ry    = w[5:4];
    op    = w[3:0];
    ld    = (pre == 2'b00) && (op == 4'd0);
    cp    = (pre == 2'b00) && (op == 4'd1);
    alu   = (pre == 2'b00) && (op >= 4'd2) && (op <= 4'd11);
    immop = (pre == 2'b10) || (pre == 2'b11);
    v      = '0;
    v.busy = 1'b1;
    if (step == 0) begin
      v.ext  = 1'b1;
      v.irin = 1'b1;
    end else if (step == 1) begin
      if (ld) begin
        v.ext = 1'b1; v.rin = rx; v.enr = 1'b1; v.done = 1'b1;
      end else if (cp) begin
        v.rout = ry; v.enw = 1'b1; v.rin = rx; v.enr = 1'b1; v.done = 1'b1;
      end else if (alu || immop) begin
        v.rout = rx; v.enw = 1'b1; v.ain = 1'b1;
      end else begin
        v.err = 1'b1; v.done = 1'b1;
      end
    end else if (step == 2) begin
      v.gin = 1'b1;
      if (immop) begin
        v.imm_oe  = 1'b1;
        v.imm     = {4'b0000, w[5:0]};
        v.alucont = (pre == 2'b11) ? 4'd3 : 4'd2;
      end else begin
        v.rout    = ry;
        v.enw     = 1'b1;
        v.alucont = op;
      end
    end else begin
      v.gout = 1'b1; v.rin = rx; v.enr = 1'b1; v.done = 1'b1;
    end
    return v;
  endfunction

  function automatic int step_count(input logic [9:0] w);
    if (w[9])
      return 4;
    if ((w[9:8] == 2'b00) && (w[3:0] >= 4'd2) && (w[3:0] <= 4'd11))
      return 4;
    return 2;
  endfunction

  // Queue one instruction: exec raised in the IDLE cycle, instruction held
  // through FETCH, then exec_steps/operand presented during later steps.
  task automatic push_instr(input string nm, input logic [9:0] w,
                            input logic exec_steps, input logic [9:0] operand);
    int n;
    n = step_count(w);
    for (int s = 0; s < n; s++) begin
      if (s == 0)      stim_q.push_back({1'b1, w});
      else if (s == 1) stim_q.push_back({exec_steps, w});
      else             stim_q.push_back({exec_steps, operand});
      exp_q.push_back(exp_step(w, s));
      name_q.push_back($sformatf("%s_step%0d", nm, s));
    end
  endtask

  task automatic push_idle(input string nm, input logic ex, input logic [9:0] w);
    stim_q.push_back({ex, w});
    exp_q.push_back('0);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    vec_t got;
    rst = 1'b1;
    ifc.exec = 1'b0;
    ifc.inst_in = '0;
    @(negedge clk);
    got = snap();
    tests++;
    if (got !== vec_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", got, vec_t'(0));
    end
    ifc.exec = 1'b1;
    ifc.inst_in = 10'h012;
    @(negedge clk);
    got = snap();
    tests++;
    if (got !== vec_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_holds_exec: got %h expected %h", got, vec_t'(0));
    end
    ifc.exec = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    got = snap();
    tests++;
    if (got !== vec_t'(0)) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", got, vec_t'(0));
    end
  endtask

  task automatic test_ld_cp();
    vec_t got, ev;
    string nm;
    push_instr("ld_r1", 10'h040, 1'b0, 10'h155);
    push_idle("ld_r1_idle", 1'b0, 10'h155);
    push_instr("cp_r2_r3", 10'h0B1, 1'b0, 10'h000);
    push_idle("cp_idle", 1'b0, 10'h000);
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
  endtask

  task automatic test_alu();
    vec_t got, ev;
    string nm;
    push_instr("add_r0_r1", 10'h012, 1'b0, 10'h000);
    push_idle("add_idle", 1'b0, 10'h000);
    push_instr("op11_r3_r2", 10'h0EB, 1'b0, 10'h000);
    push_idle("op11_idle", 1'b0, 10'h000);
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
  endtask

  task automatic test_immediate();
    vec_t got, ev;
    string nm;
    push_instr("addi_r2_2a", 10'h2AA, 1'b0, 10'h3FF);
    push_idle("addi_idle", 1'b0, 10'h000);
    push_instr("subi_r1_3f", 10'h37F, 1'b0, 10'h000);
    push_idle("subi_idle", 1'b0, 10'h000);
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t got, ev;
    string nm;
    push_instr("ill_prefix01", 10'h100, 1'b0, 10'h000);
    push_idle("ill_prefix01_idle", 1'b0, 10'h000);
    push_instr("ill_op15", 10'h00F, 1'b0, 10'h000);
    push_idle("ill_op15_idle", 1'b0, 10'h000);
    push_instr("ill_op12", 10'h00C, 1'b0, 10'h000);
    push_idle("ill_op12_idle", 1'b0, 10'h000);
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
  endtask

  task automatic test_exec_ignored();
    vec_t got, ev;
    string nm;
    push_instr("busy_add", 10'h012, 1'b1, 10'h2AA);
    push_idle("busy_add_idle", 1'b1, 10'h2AA);
    push_idle("busy_add_idle2", 1'b0, 10'h000);
    push_idle("busy_add_idle3", 1'b0, 10'h000);
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t got, ev;
    string nm;
    push_instr("b2b_ld_r3", 10'h0C0, 1'b1, 10'h2AA);
    push_idle("b2b_gap1", 1'b1, 10'h062);
    push_instr("b2b_add_r1_r2", 10'h062, 1'b1, 10'h000);
    push_idle("b2b_gap2", 1'b1, 10'h100);
    push_instr("b2b_illegal", 10'h100, 1'b1, 10'h000);
    push_idle("b2b_gap3", 1'b0, 10'h000);
    push_idle("b2b_idle", 1'b0, 10'h000);
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t got, ev;
    string nm;
    for (int s = 0; s < 3; s++) begin
      stim_q.push_back((s == 0) ? {1'b1, 10'h012} : {1'b0, 10'h012});
      exp_q.push_back(exp_step(10'h012, s));
      name_q.push_back($sformatf("abort_add_step%0d", s));
    end
    while (exp_q.size() > 0) begin
      {ifc.exec, ifc.inst_in} = stim_q.pop_front();
      @(negedge clk);
      got = snap(); ev = exp_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (got !== ev) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", nm, got, ev);
      end
    end
    #2 rst = 1'b1;
    #1;
    got = snap();
    tests++;
    if (got !== vec_t'(0)) begin
      failures++;
      $display("[TB] FAIL abort_async_clear: got %h expected %h", got, vec_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = snap();
      tests++;
      if (got !== vec_t'(0)) begin
        failures++;
        $display("[TB] FAIL abort_stays_idle_%0d: got %h expected %h", c, got, vec_t'(0));
      end
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    rst = 1'b1;
    ifc.exec = 1'b0;
    ifc.inst_in = '0;
    test_reset();
    test_ld_cp();
    test_alu();
    test_immediate();
    test_illegal();
    test_exec_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
